if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 172 +++++++++++++++++
 tb/tb_if_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch front end: issues PC-addressed requests to instruction
// memory under a credit limit, pairs in-order responses with their PCs and
// buffers them in a small instruction queue for decode. A flush discards all
// queued and in-flight work; late responses are counted off via drop_cnt.
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the rising clock edge. pc_valid/pc_ready is the PC register channel,
// imem_req_valid/imem_req_ready the memory request channel (same transfer as
// the PC channel), inst_valid/inst_ready the decode channel. imem_rsp_valid has
// no ready: memory responses are always absorbed.
module if_fetch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 2;

   // occupancy counters
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;

   // instruction queue and pending-PC FIFO pointers
   logic [PW-1:0] q_rd_ptr_q, q_rd_ptr_d;
   logic [PW-1:0] q_wr_ptr_q, q_wr_ptr_d;
   logic [PW-1:0] pf_rd_ptr_q, pf_rd_ptr_d;
   logic [PW-1:0] pf_wr_ptr_q, pf_wr_ptr_d;

   // storage
   logic [31:0] q_data_q [DEPTH];
   logic [31:0] q_data_d [DEPTH];
   logic [31:0] q_pc_q   [DEPTH];
   logic [31:0] q_pc_d   [DEPTH];
   logic [31:0] pf_pc_q  [DEPTH];
   logic [31:0] pf_pc_d  [DEPTH];

   logic [SW-1:0] credit_sum;
   logic [SW-1:0] drop_sum;
   logic          credit;
   logic          accept;
   logic          rsp_take;
   logic          rsp_drop;
   logic          rsp_orphan;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Credit and handshake decode from registered occupancy only
   always_comb begin
      credit_sum     = SW'(drop_cnt_q) + SW'(outstanding_q) + SW'(count_q);
      credit         = (credit_sum < SW'(DEPTH));
      imem_req_valid = pc_valid && credit && !flush;
      imem_req_addr  = pc_in;
      pc_ready       = imem_req_ready && credit && !flush;
      accept         = pc_valid && pc_ready;
      inst_valid     = (count_q != '0);
      inst_out       = inst_valid ? q_data_q[q_rd_ptr_q] : '0;
      inst_pc        = inst_valid ? q_pc_q[q_rd_ptr_q] : '0;
      pop            = inst_valid && inst_ready && !flush;
      rsp_orphan     = (outstanding_q == '0) && (drop_cnt_q == '0);
      rsp_take       = imem_rsp_valid && (drop_cnt_q == '0) && !rsp_orphan && !flush;
      rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
      drop_sum       = SW'(drop_cnt_q) + SW'(outstanding_q)
                       - ((imem_rsp_valid && !rsp_orphan) ? SW'(1) : SW'(0));
   end

   // Next-state computation for counters, pointers and storage
   always_comb begin
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      q_rd_ptr_d    = q_rd_ptr_q;
      q_wr_ptr_d    = q_wr_ptr_q;
      pf_rd_ptr_d   = pf_rd_ptr_q;
      pf_wr_ptr_d   = pf_wr_ptr_q;
      q_data_d      = q_data_q;
      q_pc_d        = q_pc_q;
      pf_pc_d       = pf_pc_q;
      if (flush) begin
         // everything in flight becomes a response to discard
         count_d       = '0;
         outstanding_d = '0;
         drop_cnt_d    = drop_sum[CW-1:0];
         q_rd_ptr_d    = '0;
         q_wr_ptr_d    = '0;
         pf_rd_ptr_d   = '0;
         pf_wr_ptr_d   = '0;
      end else begin
         if (accept) begin
            pf_pc_d[pf_wr_ptr_q] = pc_in;
            pf_wr_ptr_d          = ptr_inc(pf_wr_ptr_q);
         end
         if (rsp_take) begin
            q_data_d[q_wr_ptr_q] = imem_rsp_data;
            q_pc_d[q_wr_ptr_q]   = pf_pc_q[pf_rd_ptr_q];
            q_wr_ptr_d           = ptr_inc(q_wr_ptr_q);
            pf_rd_ptr_d          = ptr_inc(pf_rd_ptr_q);
         end
         if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (pop) begin
            q_rd_ptr_d = ptr_inc(q_rd_ptr_q);
         end
         case ({accept, rsp_take})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
         endcase
         case ({rsp_take, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         q_rd_ptr_q    <= '0;
         q_wr_ptr_q    <= '0;
         pf_rd_ptr_q   <= '0;
         pf_wr_ptr_q   <= '0;
      end else begin
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         q_rd_ptr_q    <= q_rd_ptr_d;
         q_wr_ptr_q    <= q_wr_ptr_d;
         pf_rd_ptr_q   <= pf_rd_ptr_d;
         pf_wr_ptr_q   <= pf_wr_ptr_d;
      end
   end

   // Data storage; contents are only meaningful behind valid pointers
   always_ff @(posedge clk) begin
      q_data_q <= q_data_d;
      q_pc_q   <= q_pc_d;
      pf_pc_q  <= pf_pc_d;
   end

   // A response with nothing outstanding and nothing to drop is a memory bug
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> !rsp_orphan);

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by a long randomized run
// against an in-order memory model and a PC-stream scoreboard.
module tb_if_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   // clock / reset
   always #5 clk = ~clk;

   if_fetch #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc)
   );

   int n_checks = 0;
   int n_errors = 0;

   // stimulus knobs
   int          lat_lo = 1;
   int          lat_hi = 1;
   int          pct_pcv = 100;
   int          pct_reqr = 100;
   int          pct_rdy = 100;
   int          flush_pm = 0;
   logic        force_flush = 1'b0;
   logic        force_rst = 1'b0;
   logic        rand_target = 1'b0;
   logic [31:0] flush_target = 32'h100;

   // reference model state
   logic [31:0] pc_reg = '0;
   logic [31:0] exp_q[$];
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   int          last_due = -1;
   int          cyc = 0;
   int          pops_mark = 0;
   logic [31:0] first_pc_mark = '0;
   logic        s_pc_ready;
   logic        s_inst_valid;
   logic        held = 1'b0;
   logic [31:0] held_pc;
   logic [31:0] held_out;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // one clock cycle: drive, check before the edge, update the model after it
   task automatic step();
      logic        acc;
      logic        pop;
      logic        rspv;
      logic [31:0] smp_pc;
      logic [31:0] exp_pc;
      int          due;
      rst            = force_rst;
      flush          = force_flush || (flush_pm > 0 && $urandom_range(999) < flush_pm);
      pc_valid       = ($urandom_range(99) < pct_pcv);
      imem_req_ready = ($urandom_range(99) < pct_reqr);
      inst_ready     = ($urandom_range(99) < pct_rdy);
      pc_in          = pc_reg;
      if (rand_target) flush_target = {20'h0, 10'($urandom_range(1023)), 2'b00};
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_addr_q[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #3;
      acc          = pc_valid && pc_ready;
      pop          = inst_valid && inst_ready && !flush && !rst;
      rspv         = imem_rsp_valid;
      smp_pc       = inst_pc;
      s_pc_ready   = pc_ready;
      s_inst_valid = inst_valid;
      if (!rst) begin
         if (held) begin
            check("hold_pc", inst_pc, held_pc);
            check("hold_out", inst_out, held_out);
         end
         if (flush) check("no_req_on_flush", {31'b0, imem_req_valid | pc_ready}, 32'd0);
         if (pc_ready) check("ready_needs_mem_ready", {31'b0, imem_req_ready}, 32'd1);
         if (imem_req_valid) check("req_addr", imem_req_addr, pc_in);
         check("in_flight_bound", {31'b0, mem_addr_q.size() <= DEPTH}, 32'd1);
         if (pop) begin
            check("pop_has_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            exp_pc = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
            check("inst_pc", inst_pc, exp_pc);
            check("inst_out", inst_out, mem_word(exp_pc));
         end
      end
      held     = !rst && inst_valid && !inst_ready && !flush;
      held_pc  = inst_pc;
      held_out = inst_out;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         mem_addr_q.delete();
         mem_due_q.delete();
         pc_reg    = '0;
         pops_mark = 0;
         held      = 1'b0;
      end else begin
         if (pop) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pops_mark++;
            if (pops_mark == 1) first_pc_mark = smp_pc;
         end
         if (rspv) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
         end
         if (flush) begin
            exp_q.delete();
            pc_reg = flush_target;
         end
         if (acc) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr_q.push_back(pc_in);
            mem_due_q.push_back(due);
            exp_q.push_back(pc_in);
            pc_reg = pc_in + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      force_rst = 1'b1;
      step();
      step();
      force_rst = 1'b0;
   endtask

   task automatic set_knobs(input int llo, input int lhi, input int pcv, input int reqr, input int rdy);
      lat_lo   = llo;
      lat_hi   = lhi;
      pct_pcv  = pcv;
      pct_reqr = reqr;
      pct_rdy  = rdy;
      flush_pm = 0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc_in = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

      // reset state
      set_knobs(1, 1, 100, 100, 100);
      do_reset();
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst_out", inst_out, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      pc_valid = 1'b1; imem_req_ready = 1'b1; flush = 1'b0;
      #1;
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("rst_pc_ready", {31'b0, pc_ready}, 32'd1);

      // stream 0x0,0x4,0x8 with latency 1
      do_reset();
      step(); step();
      check("stream_first_valid", {31'b0, inst_valid}, 32'd1);
      check("stream_first_pc", inst_pc, 32'h0);
      for (int i = 0; i < 8; i++) step();
      check("stream_pops", {31'b0, pops_mark >= 3}, 32'd1);

      // backpressure
      do_reset();
      set_knobs(1, 1, 100, 100, 0);
      step(); step();
      step(); check("bp_no_credit_a", {31'b0, s_pc_ready}, 32'd0);
      step(); check("bp_no_credit_b", {31'b0, s_pc_ready}, 32'd0);
      check("bp_queue_valid", {31'b0, inst_valid}, 32'd1);
      pct_rdy = 100;
      step(); check("bp_pop_cycle", {31'b0, s_pc_ready}, 32'd0);
      step(); check("bp_credit_back", {31'b0, s_pc_ready}, 32'd1);

      // flush with two outstanding, late responses dropped
      do_reset();
      set_knobs(4, 4, 100, 100, 100);
      step(); step();
      force_flush = 1'b1; flush_target = 32'h100;
      step();
      force_flush = 1'b0;
      check("fl_drop_two", 32'(dut.drop_cnt_q), 32'd2);
      check("fl_empty", {31'b0, inst_valid}, 32'd0);
      step(); step(); step();
      check("fl_drop_zero", 32'(dut.drop_cnt_q), 32'd0);
      pops_mark = 0;
      for (int i = 0; i < 10; i++) step();
      check("fl_delivered", {31'b0, pops_mark > 0}, 32'd1);
      check("fl_first_pc", first_pc_mark, 32'h100);

      // flush coincident with response and decode pop
      do_reset();
      set_knobs(1, 1, 100, 100, 100);
      flush_target = 32'h200;
      step(); step();
      force_flush = 1'b1;
      step();
      force_flush = 1'b0;
      check("flr_had_inst", {31'b0, s_inst_valid}, 32'd1);
      check("flr_drop", 32'(dut.drop_cnt_q), 32'd0);
      check("flr_empty", {31'b0, inst_valid}, 32'd0);
      check("flr_count", 32'(dut.count_q), 32'd0);
      for (int i = 0; i < 6; i++) step();

      // reset mid-operation
      do_reset();
      set_knobs(1, 1, 100, 100, 0);
      step(); step();
      force_rst = 1'b1;
      step();
      force_rst = 1'b0;
      check("mrst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("mrst_count", 32'(dut.count_q), 32'd0);
      check("mrst_inst_pc", inst_pc, 32'd0);
      pc_valid = 1'b1; flush = 1'b0; imem_req_ready = 1'b0;
      #1;
      check("mrst_pc_ready_lo", {31'b0, pc_ready}, 32'd0);
      imem_req_ready = 1'b1;
      #1;
      check("mrst_pc_ready_hi", {31'b0, pc_ready}, 32'd1);

      // long randomized run
      set_knobs(1, 5, 85, 80, 60);
      flush_pm    = 30;
      rand_target = 1'b1;
      for (int i = 0; i < 10000; i++) step();

      // drain: every accepted instruction since the last flush must emerge
      rand_target = 1'b0;
      set_knobs(1, 5, 0, 100, 100);
      for (int i = 0; i < 40; i++) step();
      check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
      check("drain_mem_empty", 32'(mem_addr_q.size()), 32'd0);
      check("drain_drop", 32'(dut.drop_cnt_q), 32'd0);
      check("drain_inst_valid", {31'b0, inst_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
